bip_control_unit: RTL and testbench

- Control unit for the BIP single-cycle processor.
- Fetches 16-bit instructions from program memory using its program counter, decodes opcode[15:11] and operand[10:0], and drives the datapath controls: accumulator source select, ALU operand select, accumulator write enable, add/sub select, sign-extendable operand.
- Also drives the data-memory address and read/write strobes, and halts on HLT.
- Sits between program memory, data memory and bip_datapath.

---
 rtl/bip_pkg.sv | 39 +++
 rtl/bip_pc.sv | 23 ++
 rtl/bip_control_unit.sv | 119 +++++++++++
 tb/tb_bip_control_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: field widths, opcodes, select encodings.
package bip_pkg;

  localparam int unsigned NB_INSTRUCTION = 16;
  localparam int unsigned NB_OPCODE      = 5;
  localparam int unsigned NB_OPERAND     = 11;
  localparam int unsigned NB_PC          = 11;
  localparam int unsigned NB_DATA_ADDR   = 10;
  localparam int unsigned NB_SEL_A       = 2;
  localparam int unsigned NB_COUNT       = 16;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [NB_SEL_A-1:0] SEL_A_MEM = 2'b00;
  localparam logic [NB_SEL_A-1:0] SEL_A_IMM = 2'b01;
  localparam logic [NB_SEL_A-1:0] SEL_A_ALU = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [NB_SEL_A-1:0] sel_a;
    logic                sel_b;
    logic                wr_acc;
    logic                op_code;
    logic                wr_ram;
    logic                rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_pc.sv
// BIP program counter: increments when enabled, wraps at 2^NB_PC.
module bip_pc
  import bip_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic [NB_PC-1:0] o_pc
);

  logic [NB_PC-1:0] r_pc;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc <= '0;
    end else if (i_enable) begin
      r_pc <= r_pc + NB_PC'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: fetch/decode of 16-bit instructions, datapath and data-memory
// strobes, RUN/HALT sequencing and executed-instruction counter.
module bip_control_unit
  import bip_pkg::*;
(
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [NB_INSTRUCTION-1:0] i_instruction,
  output logic [NB_PC-1:0]          o_pc,
  output logic [NB_OPERAND-1:0]     o_operand,
  output logic [NB_DATA_ADDR-1:0]   o_data_addr,
  output logic [NB_SEL_A-1:0]       o_sel_a,
  output logic                      o_sel_b,
  output logic                      o_wr_acc,
  output logic                      o_op_code,
  output logic                      o_wr_ram,
  output logic                      o_rd_ram,
  output logic                      o_halt,
  output logic [NB_COUNT-1:0]       o_inst_count
);

  state_e                r_state;
  state_e                w_next_state;
  ctrl_t                 w_ctrl;
  logic                  w_exec;
  logic                  w_pc_en;
  logic [NB_OPCODE-1:0]  w_opcode;
  logic [NB_COUNT-1:0]   r_count;

  assign w_opcode = i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];

  // Reset gates exec so no strobe is seen while reset is held.
  assign w_exec = i_valid && (r_state == ST_RUN) && !i_reset;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ctrl       = '0;
    w_pc_en      = 1'b0;
    if (w_exec) begin
      w_pc_en = 1'b1;
      case (w_opcode)
        OP_HLT: begin
          w_next_state = ST_HALT;
          w_pc_en      = 1'b0;
        end
        OP_STO: w_ctrl.wr_ram = 1'b1;
        OP_LD: begin
          w_ctrl.rd_ram = 1'b1;
          w_ctrl.wr_acc = 1'b1;
          w_ctrl.sel_a  = SEL_A_MEM;
        end
        OP_LDI: begin
          w_ctrl.wr_acc = 1'b1;
          w_ctrl.sel_a  = SEL_A_IMM;
        end
        OP_ADD: begin
          w_ctrl.rd_ram  = 1'b1;
          w_ctrl.wr_acc  = 1'b1;
          w_ctrl.sel_a   = SEL_A_ALU;
          w_ctrl.op_code = 1'b1;
        end
        OP_ADDI: begin
          w_ctrl.wr_acc  = 1'b1;
          w_ctrl.sel_a   = SEL_A_ALU;
          w_ctrl.sel_b   = 1'b1;
          w_ctrl.op_code = 1'b1;
        end
        OP_SUB: begin
          w_ctrl.rd_ram = 1'b1;
          w_ctrl.wr_acc = 1'b1;
          w_ctrl.sel_a  = SEL_A_ALU;
        end
        OP_SUBI: begin
          w_ctrl.wr_acc = 1'b1;
          w_ctrl.sel_a  = SEL_A_ALU;
          w_ctrl.sel_b  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // HLT counts as executed; counter saturates instead of wrapping.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (w_exec && (r_count != '1)) begin
      r_count <= r_count + NB_COUNT'(1);
    end
  end

  bip_pc u_pc (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (w_pc_en),
    .o_pc     (o_pc)
  );

  assign o_operand    = i_instruction[NB_OPERAND-1:0];
  assign o_data_addr  = i_instruction[NB_DATA_ADDR-1:0];
  assign o_sel_a      = w_ctrl.sel_a;
  assign o_sel_b      = w_ctrl.sel_b;
  assign o_wr_acc     = w_ctrl.wr_acc;
  assign o_op_code    = w_ctrl.op_code;
  assign o_wr_ram     = w_ctrl.wr_ram;
  assign o_rd_ram     = w_ctrl.rd_ram;
  assign o_halt       = (r_state == ST_HALT);
  assign o_inst_count = r_count;

endmodule

// File: tb/tb_bip_control_unit.sv
// Scoreboard bench for bip_control_unit: expected controls/pc/count are pushed per
// driven instruction and compared against the DUT at the following falling edge.
module tb_bip_control_unit;
  import bip_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [10:0] operand;
  logic [9:0]  data_addr;
  logic [1:0]  sel_a;
  logic        sel_b, wr_acc, op_code, wr_ram, rd_ram, halt;
  logic [15:0] inst_count;

  typedef struct packed {
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op_code;
    logic        wr_ram;
    logic        rd_ram;
    logic        halt;
    logic [10:0] pc;
    logic [15:0] cnt;
  } obs_t;

  obs_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_halted;
  logic [15:0] cur_instr;
  logic        cur_valid;

  localparam logic [15:0] I_NOP = 16'hF800;

  bip_control_unit dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_valid       (valid),
    .i_instruction (instr),
    .o_pc          (pc),
    .o_operand     (operand),
    .o_data_addr   (data_addr),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_wr_acc      (wr_acc),
    .o_op_code     (op_code),
    .o_wr_ram      (wr_ram),
    .o_rd_ram      (rd_ram),
    .o_halt        (halt),
    .o_inst_count  (inst_count)
  );

  always #5 clk = ~clk;

  // Reference decode taken straight from the opcode table.
  function automatic obs_t predict(input logic [15:0] ins, input logic v);
    obs_t e;
    logic ex;
    e     = '0;
    ex    = v && !m_halted;
    e.halt = m_halted;
    e.pc   = m_pc;
    e.cnt  = m_cnt;
    if (ex) begin
      case (ins[15:11])
        5'd1: e.wr_ram = 1'b1;
        5'd2: begin e.rd_ram = 1'b1; e.wr_acc = 1'b1; e.sel_a = 2'b00; end
        5'd3: begin e.wr_acc = 1'b1; e.sel_a = 2'b01; end
        5'd4: begin e.rd_ram = 1'b1; e.wr_acc = 1'b1; e.sel_a = 2'b10; e.op_code = 1'b1; end
        5'd5: begin e.wr_acc = 1'b1; e.sel_a = 2'b10; e.sel_b = 1'b1; e.op_code = 1'b1; end
        5'd6: begin e.rd_ram = 1'b1; e.wr_acc = 1'b1; e.sel_a = 2'b10; end
        5'd7: begin e.wr_acc = 1'b1; e.sel_a = 2'b10; e.sel_b = 1'b1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.sel_a   = sel_a;
    o.sel_b   = sel_b;
    o.wr_acc  = wr_acc;
    o.op_code = op_code;
    o.wr_ram  = wr_ram;
    o.rd_ram  = rd_ram;
    o.halt    = halt;
    o.pc      = pc;
    o.cnt     = inst_count;
    return o;
  endfunction

  // Called just after a rising edge; leaves time at the next falling edge.
  task automatic drive_step(input logic [15:0] ins, input logic v);
    instr     = ins;
    valid     = v;
    cur_instr = ins;
    cur_valid = v;
    q.push_back(predict(ins, v));
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_valid && !m_halted) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (cur_instr[15:11] == 5'd0) m_halted = 1'b1;
      else m_pc = m_pc + 11'd1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    instr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_pc     = '0;
    m_cnt    = '0;
    m_halted = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t exp;
    rst   = 1'b1;
    valid = 1'b1;
    instr = 16'h0803;
    #3;
    got = sample();
    exp = '0;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", got, exp);
    end
  endtask

  task automatic test_program();
    logic [15:0] prog[4];
    obs_t got;
    obs_t exp;
    prog = '{16'h1805, 16'h2FFE, 16'h0803, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      drive_step(prog[i], 1'b1);
      got = sample();
      exp = q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL program_step%0d: got %h required %h", i, got, exp);
      end
      n_tests++;
      if (operand !== prog[i][10:0] || data_addr !== prog[i][9:0]) begin
        n_fail++;
        $display("FAIL program_fields%0d: operand %h addr %h required %h %h",
                 i, operand, data_addr, prog[i][10:0], prog[i][9:0]);
      end
      advance();
    end
  endtask

  task automatic test_halt_lock();
    obs_t got;
    obs_t exp;
    for (int i = 0; i < 5; i++) begin
      drive_step(16'h1805, 1'b1);
      got = sample();
      exp = q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL halt_lock%0d: got %h required %h", i, got, exp);
      end
      n_tests++;
      if (halt !== 1'b1 || pc !== 11'd3 || inst_count !== 16'd4 || wr_acc !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_state%0d: halt %b pc %0d count %0d wr_acc %b required 1 3 4 0",
                 i, halt, pc, inst_count, wr_acc);
      end
      advance();
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (pc !== 11'd0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_halt: pc %0d halt %b required 0 0", pc, halt);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid    = 1'b0;
    m_pc     = '0;
    m_cnt    = '0;
    m_halted = 1'b0;
    q.delete();
  endtask

  task automatic test_ld_sub();
    logic [15:0] prog[2];
    obs_t got;
    obs_t exp;
    prog = '{16'h1007, 16'h3007};
    for (int i = 0; i < 2; i++) begin
      drive_step(prog[i], 1'b1);
      got = sample();
      exp = q.pop_front();
      n_tests++;
      if (got !== exp || data_addr !== 10'd7) begin
        n_fail++;
        $display("FAIL ld_sub%0d: got %h addr %0d required %h addr 7", i, got, data_addr, exp);
      end
      advance();
    end
  endtask

  task automatic test_valid_toggle();
    logic       vals[4];
    logic [10:0] exp_pc[4];
    obs_t got;
    obs_t exp;
    vals   = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_pc = '{11'd0, 11'd1, 11'd1, 11'd1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_step(I_NOP, vals[i]);
      got = sample();
      exp = q.pop_front();
      n_tests++;
      if (got !== exp || pc !== exp_pc[i]) begin
        n_fail++;
        $display("FAIL valid_toggle%0d: got %h pc %0d required %h pc %0d",
                 i, got, pc, exp, exp_pc[i]);
      end
      advance();
    end
    drive_step(I_NOP, 1'b0);
    got = sample();
    exp = q.pop_front();
    n_tests++;
    if (got !== exp || pc !== 11'd2 || inst_count !== 16'd2) begin
      n_fail++;
      $display("FAIL valid_toggle_end: got %h pc %0d required %h pc 2", got, pc, exp);
    end
    advance();
  endtask

  task automatic test_wrap();
    obs_t got;
    obs_t exp;
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      drive_step(I_NOP, 1'b1);
      got = sample();
      exp = q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got %h required %h", i, got, exp);
      end
      advance();
    end
    drive_step(I_NOP, 1'b0);
    got = sample();
    exp = q.pop_front();
    n_tests++;
    if (got !== exp || pc !== 11'd0 || inst_count !== 16'd2048) begin
      n_fail++;
      $display("FAIL wrap_end: pc %0d count %0d required 0 2048", pc, inst_count);
    end
    advance();
  endtask

  task automatic test_reset_during_sto();
    obs_t got;
    obs_t exp;
    do_reset();
    drive_step(I_NOP, 1'b1);
    got = sample();
    exp = q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sto_pre: got %h required %h", got, exp);
    end
    advance();
    drive_step(16'h0803, 1'b1);
    got = sample();
    exp = q.pop_front();
    n_tests++;
    if (got !== exp || wr_ram !== 1'b1) begin
      n_fail++;
      $display("FAIL sto_strobe: got %h required %h", got, exp);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (wr_ram !== 1'b0 || pc !== 11'd0) begin
      n_fail++;
      $display("FAIL sto_reset_drop: wr_ram %b pc %0d required 0 0", wr_ram, pc);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_pc     = '0;
    m_cnt    = '0;
    m_halted = 1'b0;
    q.delete();
    drive_step(16'h1805, 1'b1);
    got = sample();
    exp = q.pop_front();
    n_tests++;
    if (got !== exp || pc !== 11'd0) begin
      n_fail++;
      $display("FAIL sto_refetch: got %h pc %0d required %h pc 0", got, pc, exp);
    end
    advance();
  endtask

  initial begin
    rst       = 1'b1;
    valid     = 1'b0;
    instr     = '0;
    m_pc      = '0;
    m_cnt     = '0;
    m_halted  = 1'b0;
    cur_instr = '0;
    cur_valid = 1'b0;
    test_reset();
    do_reset();
    test_program();
    test_halt_lock();
    test_ld_sub();
    test_valid_toggle();
    test_wrap();
    test_reset_during_sto();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
